// File: rtl/alu_share_arbiter.sv
// Two-requester front end for one shared combinational 8-bit ALU: round-robin grant
// with a bounded lock, a private SC/ZERO/GREATER set per requester, one registered response per op.
module alu_share_arbiter #(
   parameter logic [3:0] OP_COMP  = 4'd10,
   parameter logic [3:0] OP_NOP   = 4'd15,
   parameter int         MAX_LOCK = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [1:0]  i_req_valid,
   output logic [1:0]  o_req_ready,
   input  logic [7:0]  i_req_op,
   input  logic [15:0] i_req_a,
   input  logic [15:0] i_req_b,
   input  logic [1:0]  i_req_lock,
   output logic [1:0]  o_rsp_valid,
   output logic [7:0]  o_rsp_out,
   output logic [5:0]  o_rsp_flags,
   output logic [3:0]  o_alu_op,
   output logic [7:0]  o_alu_a,
   output logic [7:0]  o_alu_b,
   output logic        o_alu_sc_in,
   output logic        o_alu_zero_in,
   output logic        o_alu_greater_in,
   input  logic [7:0]  i_alu_out,
   input  logic        i_alu_sc_out,
   input  logic        i_alu_zero,
   input  logic        i_alu_greater
);

   localparam int CW = $clog2(MAX_LOCK + 1);

   logic [3:0]    w_op [2];
   logic [7:0]    w_a  [2];
   logic [7:0]    w_b  [2];
   logic [1:0]    w_sc;
   logic [1:0]    w_zero;
   logic [1:0]    w_gt;

   logic [1:0]    w_grant;
   logic          w_xfer;
   logic          w_sel;
   logic          w_lock_hold;
   logic [CW-1:0] w_cnt_inc;

   logic [1:0]    r_rsp_valid;
   logic [7:0]    r_rsp_out;
   logic          r_last;
   logic          r_lock_active;
   logic          r_lock_owner;
   logic [CW-1:0] r_lock_cnt;

   // Per-requester operand unpacking and private flag registers.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : gen_req
         logic r_sc;
         logic r_zero;
         logic r_gt;

         assign w_op[gi] = i_req_op[4*gi +: 4];
         assign w_a[gi]  = i_req_a[8*gi +: 8];
         assign w_b[gi]  = i_req_b[8*gi +: 8];

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_sc   <= 1'b0;
               r_zero <= 1'b0;
               r_gt   <= 1'b0;
            end else if (w_grant[gi]) begin
               r_sc <= i_alu_sc_out;
               if (w_op[gi] == OP_COMP) begin
                  r_zero <= i_alu_zero;
                  r_gt   <= i_alu_greater;
               end
            end
         end

         assign w_sc[gi]   = r_sc;
         assign w_zero[gi] = r_zero;
         assign w_gt[gi]   = r_gt;
         assign o_rsp_flags[3*gi +: 3] = {r_sc, r_zero, r_gt};
      end
   endgenerate

   assign w_lock_hold = r_lock_active & i_req_valid[r_lock_owner];

   always_comb begin
      w_grant = 2'b00;
      if (w_lock_hold) begin
         w_grant[r_lock_owner] = 1'b1;
      end else begin
         case (i_req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
         endcase
      end
   end

   assign w_xfer = |w_grant;
   // When idle the flag inputs follow the last requester served.
   assign w_sel  = w_xfer ? w_grant[1] : r_last;

   assign o_req_ready      = w_grant;
   assign o_alu_op         = w_xfer ? w_op[w_sel] : OP_NOP;
   assign o_alu_a          = w_xfer ? w_a[w_sel]  : 8'h00;
   assign o_alu_b          = w_xfer ? w_b[w_sel]  : 8'h00;
   assign o_alu_sc_in      = w_sc[w_sel];
   assign o_alu_zero_in    = w_zero[w_sel];
   assign o_alu_greater_in = w_gt[w_sel];

   assign w_cnt_inc = (r_lock_active && (r_lock_owner == w_sel)) ? r_lock_cnt + 1'b1 : CW'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rsp_valid   <= 2'b00;
         r_rsp_out     <= 8'h00;
         r_last        <= 1'b1;
         r_lock_active <= 1'b0;
         r_lock_owner  <= 1'b0;
         r_lock_cnt    <= '0;
      end else begin
         r_rsp_valid <= w_grant;
         if (w_xfer) begin
            r_rsp_out <= i_alu_out;
            r_last    <= w_sel;
         end
         // Reaching the grant cap drops the lock; LAST then hands the next tie to the other side.
         if (w_xfer && i_req_lock[w_sel] && (w_cnt_inc < CW'(MAX_LOCK))) begin
            r_lock_active <= 1'b1;
            r_lock_owner  <= w_sel;
            r_lock_cnt    <= w_cnt_inc;
         end else begin
            r_lock_active <= 1'b0;
            r_lock_cnt    <= '0;
         end
      end
   end

   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_out   = r_rsp_out;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural model of the shared ALU.
module tb_alu_share_arbiter;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_LSH  = 4'd4;
   localparam logic [3:0] OP_COMP = 4'd10;
   localparam logic [3:0] OP_NOP  = 4'd15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [7:0]  req_op = '0;
   logic [15:0] req_a = '0;
   logic [15:0] req_b = '0;
   logic [1:0]  req_lock = '0;
   logic [1:0]  rsp_valid;
   logic [7:0]  rsp_out;
   logic [5:0]  rsp_flags;
   logic [3:0]  alu_op;
   logic [7:0]  alu_a, alu_b;
   logic        alu_sc_in, alu_zero_in, alu_greater_in;
   logic [7:0]  alu_out;
   logic        alu_sc_out, alu_zero, alu_greater;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] v;
      logic [7:0] o;
   } rsp_t;
   rsp_t sb[$];

   logic m_sc [2];
   logic m_z  [2];
   logic m_g  [2];

   always #5 clk = ~clk;

   alu_share_arbiter dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b), .i_req_lock(req_lock),
      .o_rsp_valid(rsp_valid), .o_rsp_out(rsp_out), .o_rsp_flags(rsp_flags),
      .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b),
      .o_alu_sc_in(alu_sc_in), .o_alu_zero_in(alu_zero_in), .o_alu_greater_in(alu_greater_in),
      .i_alu_out(alu_out), .i_alu_sc_out(alu_sc_out),
      .i_alu_zero(alu_zero), .i_alu_greater(alu_greater)
   );

   // Shared ALU: returns {out, sc, zero, greater}.
   function automatic logic [10:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                           input logic sc, input logic z, input logic g);
      logic [8:0] t;
      logic [10:0] r;
      r = {8'h00, sc, z, g};
      case (op)
         OP_ADD: begin
            t = {1'b0, a} + {1'b0, b} + {8'h00, sc};
            r = {t[7:0], t[8], z, g};
         end
         OP_SUB: begin
            t = {1'b0, a} - {1'b0, b} - {8'h00, sc};
            r = {t[7:0], t[8], z, g};
         end
         OP_LSH:  r = {a[6:0], sc, a[7], z, g};
         OP_COMP: r = {8'h00, sc, (a == b), (a > b)};
         default: r = {8'h00, sc, z, g};
      endcase
      return r;
   endfunction

   always_comb begin
      {alu_out, alu_sc_out, alu_zero, alu_greater} =
         alu_ref(alu_op, alu_a, alu_b, alu_sc_in, alu_zero_in, alu_greater_in);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [5:0] model_flags();
      return {m_sc[1], m_z[1], m_g[1], m_sc[0], m_z[0], m_g[0]};
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 2; i++) begin
         m_sc[i] = 1'b0;
         m_z[i]  = 1'b0;
         m_g[i]  = 1'b0;
      end
      sb.delete();
   endtask

   task automatic check_rsp();
      rsp_t e;
      if (sb.size() == 0) return;
      e = sb.pop_front();
      check("rsp_valid", 32'(rsp_valid), 32'(e.v));
      if (e.v != 2'b00) begin
         check("rsp_out", 32'(rsp_out), 32'(e.o));
         $display("txn rsp valid=%b out=%h flags=%b", rsp_valid, rsp_out, rsp_flags);
      end
      check("rsp_flags", 32'(rsp_flags), 32'(model_flags()));
   endtask

   task automatic run_cycle(input logic [1:0] v,
                            input logic [3:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                            input logic [3:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                            input logic [1:0] lk, input logic [1:0] exp_gnt);
      rsp_t e;
      logic [10:0] r;
      int idx;
      @(negedge clk);
      check_rsp();
      req_valid = v;
      req_op    = {op1, op0};
      req_a     = {a1, a0};
      req_b     = {b1, b0};
      req_lock  = lk;
      #1;
      check("req_ready", 32'(req_ready), 32'(exp_gnt));
      e.v = exp_gnt;
      e.o = 8'h00;
      if (exp_gnt == 2'b00) begin
         check("alu_op_idle", 32'(alu_op), 32'(OP_NOP));
      end else begin
         idx = exp_gnt[1] ? 1 : 0;
         r = idx ? alu_ref(op1, a1, b1, m_sc[1], m_z[1], m_g[1])
                 : alu_ref(op0, a0, b0, m_sc[0], m_z[0], m_g[0]);
         check("alu_a", 32'(alu_a), idx ? 32'(a1) : 32'(a0));
         e.o = r[10:3];
         m_sc[idx] = r[2];
         if ((idx ? op1 : op0) == OP_COMP) begin
            m_z[idx] = r[1];
            m_g[idx] = r[0];
         end
      end
      sb.push_back(e);
   endtask

   task automatic idle();
      run_cycle(2'b00, OP_NOP, 8'h00, 8'h00, OP_NOP, 8'h00, 8'h00, 2'b00, 2'b00);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = '0;
      req_lock  = '0;
      clear_model();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      clear_model();
      do_reset();
      #1;
      check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      check("reset_rsp_out", 32'(rsp_out), 32'h0);
      check("reset_flags", 32'(rsp_flags), 32'h0);
      check("reset_alu_op", 32'(alu_op), 32'(OP_NOP));

      // Single ADD from req 0
      run_cycle(2'b01, OP_ADD, 8'h05, 8'h03, OP_NOP, 8'h00, 8'h00, 2'b00, 2'b01);
      idle();

      // Round-robin with both requesters valid
      do_reset();
      for (int i = 0; i < 4; i++) begin
         run_cycle(2'b11, OP_ADD, 8'(16 + i), 8'h01, OP_SUB, 8'h20, 8'(i), 2'b00,
                   (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      idle();

      // COMP flags on req 1 held through a later ADD
      run_cycle(2'b10, OP_NOP, 8'h00, 8'h00, OP_COMP, 8'h07, 8'h07, 2'b00, 2'b10);
      run_cycle(2'b10, OP_NOP, 8'h00, 8'h00, OP_ADD, 8'h01, 8'h02, 2'b00, 2'b10);
      idle();
      check("req1_zero_greater", 32'(rsp_flags[4:3]), 32'h2);

      // Lock capped at four grants, then the other requester wins
      do_reset();
      for (int i = 0; i < 5; i++) begin
         run_cycle(2'b11, OP_ADD, 8'(i), 8'h10, OP_ADD, 8'h40, 8'(i), 2'b01,
                   (i < 4) ? 2'b01 : 2'b10);
      end
      idle();

      // Lock released when holder drops valid; lock never blocks an idle holder
      do_reset();
      run_cycle(2'b01, OP_ADD, 8'h11, 8'h22, OP_NOP, 8'h00, 8'h00, 2'b01, 2'b01);
      run_cycle(2'b10, OP_NOP, 8'h00, 8'h00, OP_ADD, 8'h33, 8'h44, 2'b00, 2'b10);
      run_cycle(2'b11, OP_ADD, 8'h01, 8'h01, OP_ADD, 8'h02, 8'h02, 2'b00, 2'b01);
      idle();

      // Carry from LSH feeds the following ADD
      do_reset();
      run_cycle(2'b01, OP_LSH, 8'h80, 8'h00, OP_NOP, 8'h00, 8'h00, 2'b00, 2'b01);
      run_cycle(2'b01, OP_ADD, 8'h01, 8'h01, OP_NOP, 8'h00, 8'h00, 2'b00, 2'b01);
      check("alu_sc_in_add", 32'(alu_sc_in), 32'h1);
      idle();

      // Reset right after a transfer wipes response and flags at once
      do_reset();
      run_cycle(2'b10, OP_NOP, 8'h00, 8'h00, OP_COMP, 8'h09, 8'h03, 2'b00, 2'b10);
      @(negedge clk);
      check_rsp();
      req_valid = 2'b00;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(rsp_valid), 32'h0);
      check("async_rst_flags", 32'(rsp_flags), 32'h0);
      check("async_rst_out", 32'(rsp_out), 32'h0);
      clear_model();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_cycle(2'b11, OP_ADD, 8'h02, 8'h03, OP_ADD, 8'h04, 8'h05, 2'b00, 2'b01);
      idle();
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
